frame_crc: RTL

FRAME_CRC -- requirements
Module: frame_crc

---
 rtl/frame_crc.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/frame_crc.sv
// frame_crc: CRC-32 signature and active-pixel count of one video frame.
// Ports: CLK/RST (async, active-high), PCE pixel enable, HCNT/VCNT raster
//   position, VGA_R/G/B pixel colour, ARM/CONT/ABORT control;
//   BUSY, VALID (one-cycle report pulse), CRC and PIXCNT of last frame.
module frame_crc #(
   parameter int HPERIOD = 800,
   parameter int HFRONT  = 16,
   parameter int HWIDTH  = 96,
   parameter int HBACK   = 48,
   parameter int VPERIOD = 525,
   parameter int VFRONT  = 10,
   parameter int VWIDTH  = 2,
   parameter int VBACK   = 33,
   parameter int CW      = 4,
   parameter int HW      = 10,
   parameter int VW      = 10,
   parameter int PW      = 20
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          PCE,
   input  logic [HW-1:0] HCNT,
   input  logic [VW-1:0] VCNT,
   input  logic [CW-1:0] VGA_R,
   input  logic [CW-1:0] VGA_G,
   input  logic [CW-1:0] VGA_B,
   input  logic          ARM,
   input  logic          CONT,
   input  logic          ABORT,
   output logic          BUSY,
   output logic          VALID,
   output logic [31:0]   CRC,
   output logic [PW-1:0] PIXCNT
);

   localparam int DW = 3 * CW;
   localparam logic [HW-1:0] HS    = HW'(HFRONT + HWIDTH + HBACK);
   localparam logic [VW-1:0] VS    = VW'(VFRONT + VWIDTH + VBACK);
   localparam logic [HW-1:0] HLAST = HW'(HPERIOD - 1);
   localparam logic [VW-1:0] VLAST = VW'(VPERIOD - 1);
   localparam logic [31:0]   POLY  = 32'h04C1_1DB7;
   localparam logic [31:0]   SEED  = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_SOF,
      CAPTURE,
      REPORT
   } state_t;

   state_t        state_q, state_d;
   logic          mode_q, mode_d;
   logic [31:0]   acc_q, acc_d;
   logic [31:0]   crc_q, crc_d;
   logic [PW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] pixcnt_q, pixcnt_d;

   logic [DW-1:0] pix;
   logic          active;
   logic          sof;
   logic          eof;
   logic [PW-1:0] cnt_inc;

   // One whole pixel word per cycle, MSB first, unrolled bit-serial CRC.
   function automatic logic [31:0] crc_step(input logic [31:0] c_in,
                                            input logic [DW-1:0] w);
      logic [31:0] c;
      logic        fb;
      c = c_in;
      for (int i = DW - 1; i >= 0; i--) begin
         fb = c[31] ^ w[i];
         c  = {c[30:0], 1'b0};
         if (fb) c = c ^ POLY;
      end
      return c;
   endfunction

   assign pix     = {VGA_R, VGA_G, VGA_B};
   assign active  = PCE && (HCNT >= HS) && (VCNT >= VS);
   assign sof     = PCE && (HCNT == HS) && (VCNT == VS);
   assign eof     = PCE && (HCNT == HLAST) && (VCNT == VLAST);
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      crc_d    = crc_q;
      pixcnt_d = pixcnt_q;
      if (ABORT) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (ARM) begin
                  state_d = WAIT_SOF;
                  mode_d  = CONT;
               end
            end
            WAIT_SOF: begin
               // The SOF pixel is the first word of the new frame.
               if (sof) begin
                  state_d = CAPTURE;
                  acc_d   = crc_step(SEED, pix);
                  cnt_d   = PW'(1);
               end
            end
            CAPTURE: begin
               if (active) begin
                  acc_d = crc_step(acc_q, pix);
                  cnt_d = cnt_inc;
               end
               // Results are loaded on the EOF edge so that they are
               // already on CRC/PIXCNT while VALID is high in REPORT.
               if (eof) begin
                  state_d  = REPORT;
                  crc_d    = acc_d;
                  pixcnt_d = cnt_d;
               end
            end
            REPORT: begin
               state_d = mode_q ? WAIT_SOF : IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= IDLE;
         mode_q   <= 1'b0;
         acc_q    <= SEED;
         cnt_q    <= '0;
         crc_q    <= '0;
         pixcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         crc_q    <= crc_d;
         pixcnt_q <= pixcnt_d;
      end
   end

   assign BUSY   = (state_q != IDLE);
   assign VALID  = (state_q == REPORT);
   assign CRC    = crc_q;
   assign PIXCNT = pixcnt_q;

endmodule
